util_filter_sched: RTL and testbench
====================================

// Module: util_filter_sched
// PURPOSE
//   Time-multiplexed glitch-filter scheduler: one shared compare/count engine serves NUM_CH inputs.
//   A round-robin scan pointer visits one channel per clock. Each channel holds its own count,
//   high/low thresholds and filtered level. Used for banks of slow status/GPIO lines where
//   per-line filter instances cost too much.
// PARAMETERS
//   NUM_CH   8    number of filtered channels (>=2)
//   CNT_W    16   width of per-channel counters/thresholds; units = scan periods (NUM_CH clk)
//   CH_W     $clog2(NUM_CH) (localparam) channel index width
// PORTS
//   clk            in   1       single clock
//   rstn           in   1       reset, asynchronous assert, active-low
//   enable         in   1       1 = scan runs; 0 = scan and channel state frozen
//   filter_i       in   NUM_CH  raw inputs, synchronous to clk
//   filter_o       out  NUM_CH  filtered levels
//   cfg_valid      in   1       threshold write request
//   cfg_ready      out  1       write accepted when cfg_valid & cfg_ready
//   cfg_chan       in   CH_W    target channel
//   cfg_high_time  in   CNT_W   visits input must stay 1 before filter_o rises
//   cfg_low_time   in   CNT_W   visits input must stay 0 before filter_o falls
//   scan_ptr       out  CH_W    channel being visited this cycle
//   evt_valid      out  1       1-cycle pulse on a filtered-level change (see CONFIGURATION)
//   evt_chan       out  CH_W    channel that changed
//   evt_level      out  1       new level of that channel
// BEHAVIOUR
// - Reset (rstn=0, async): filter_o=0, all cnt=0, all thresholds=all-ones, init bits=0,
//   scan_ptr=0, cfg_ready=0, evt_*=0. cfg_ready goes 1 on the first clk after rstn release.
// - filter_i is registered once (in_q); only in_q is used by the engine.
// - Scan: enable=1 -> scan_ptr increments each clk, NUM_CH-1 wraps to 0. enable=0 -> ptr, cnt,
//   filter_o held; config writes still accepted.
// - Visit of channel c (scan_ptr==c, enable=1), evaluated on in_q[c]:
//   * init[c]==0: filter_o[c]<=in_q[c], cnt<=0, init[c]<=1; no event.
//   * in_q[c]==filter_o[c]: cnt<=0.
//   * else thr = filter_o[c] ? low_time : high_time, thr 0 treated as 1;
//     cnt+1 >= thr -> filter_o[c] toggles, cnt<=0, event; otherwise cnt<=cnt+1.
//   cnt never exceeds thr-1, so no wrap; compare in CNT_W+1 bits.
// - Latency: input change held steady -> filter_o updates after thr visits; first visit occurs
//   2..NUM_CH+1 clk after the change. filter_o registered, changes only on its channel's visit.
// - Config: cfg_ready=1 whenever out of reset. Accepted write loads both thresholds of cfg_chan
//   and clears its cnt next clk; filter_o unchanged. cfg_chan>=NUM_CH: accepted and dropped.
// - Collision: write to channel being visited same cycle -> write wins; that visit only clears
//   cnt, no toggle, no event. Visit of other channels proceeds normally.
// - Reset mid-count: everything returns to reset values immediately; re-init on next visits.
// CONFIGURATION
//   UTIL_FILTER_SCHED_EVT_EN defined: evt_valid pulses 1 clk in the cycle after a toggle, with
//     evt_chan=c and evt_level=new filter_o[c]; at most one event per clk by construction.
//   Not defined: evt_valid, evt_chan, evt_level tied to 0; event logic not built. Ports remain.
// TESTING (NUM_CH=4, CNT_W=8, UTIL_FILTER_SCHED_EVT_EN defined)
// 1 Reset, filter_i=4'b0101, enable=1 -> after <=6 clk filter_o=4'b0101, evt_valid never set.
// 2 ch1 high=3; filter_i[1] 0->1 held -> filter_o[1] rises on 3rd visit; single evt chan=1 lvl=1.
// 3 ch2 at 1, low=4; filter_i[2]=0 for 3 visits, then 1 -> filter_o[2] stays 1, cnt[2]=0.
// 4 ch0 cnt=2 of high=5; cfg write ch0 (high=5) in cycle scan_ptr==0 -> cnt 0, no toggle.
// 5 enable=0 for 20 clk mid-count of ch3 -> no change; enable=1 -> count resumes, toggles on time.
// 6 rstn low mid-count of ch1 -> filter_o=0 async; release -> ch re-init to current filter_i.

Source files
------------

// File: rtl/util_filter_sched.sv
// util_filter_sched: time-multiplexed glitch filter for a bank of NUM_CH slow inputs.
// One shared compare/count engine visits one channel per clock in round-robin order.
// Each channel keeps its own count, high/low thresholds, init bit and filtered level.
// Optional feature: define UTIL_FILTER_SCHED_EVT_EN to build the level-change event outputs;
// otherwise evt_valid/evt_chan/evt_level are tied to zero.
module util_filter_sched #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic [NUM_CH-1:0] filter_i,
    output logic [NUM_CH-1:0] filter_o,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [CNT_W-1:0]  cfg_high_time,
    input  logic [CNT_W-1:0]  cfg_low_time,
    output logic [CH_W-1:0]   scan_ptr,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_chan,
    output logic              evt_level
);

    localparam logic [CH_W-1:0] PtrLast = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]   ChLimit = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] in_q;
    logic [NUM_CH-1:0] filt_q, filt_d;
    logic [NUM_CH-1:0] init_q, init_d;
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  high_q [NUM_CH];
    logic [CNT_W-1:0]  high_d [NUM_CH];
    logic [CNT_W-1:0]  low_q  [NUM_CH];
    logic [CNT_W-1:0]  low_d  [NUM_CH];
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic              live_q;

    logic              cfg_hit;
    logic              visit_tgl;
    logic [CNT_W-1:0]  thr_raw;
    logic [CNT_W-1:0]  thr_eff;
    logic [CNT_W:0]    cnt_inc;

    // Next-state for the visited channel, config writes and the scan pointer.
    always_comb begin
        filt_d    = filt_q;
        init_d    = init_q;
        cnt_d     = cnt_q;
        high_d    = high_q;
        low_d     = low_q;
        ptr_d     = ptr_q;
        visit_tgl = 1'b0;
        cfg_hit   = cfg_valid && live_q && ({1'b0, cfg_chan} < ChLimit);
        thr_raw   = filt_q[ptr_q] ? low_q[ptr_q] : high_q[ptr_q];
        thr_eff   = (thr_raw == '0) ? CNT_W'(1) : thr_raw;
        cnt_inc   = {1'b0, cnt_q[ptr_q]} + (CNT_W + 1)'(1);

        // in_q still holds its reset value on the first cycle after reset, so the scan
        // starts one clock later (live_q) to avoid initialising channels from stale data.
        if (enable && live_q) begin
            ptr_d = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
            // A write to the visited channel wins; its cnt is cleared by the write below.
            if (!(cfg_hit && (cfg_chan == ptr_q))) begin
                if (!init_q[ptr_q]) begin
                    filt_d[ptr_q] = in_q[ptr_q];
                    init_d[ptr_q] = 1'b1;
                    cnt_d[ptr_q]  = '0;
                end else if (in_q[ptr_q] == filt_q[ptr_q]) begin
                    cnt_d[ptr_q] = '0;
                end else if (cnt_inc >= {1'b0, thr_eff}) begin
                    visit_tgl    = 1'b1;
                    cnt_d[ptr_q] = '0;
                end else begin
                    cnt_d[ptr_q] = cnt_inc[CNT_W-1:0];
                end
            end
        end

        if (visit_tgl) begin
            filt_d[ptr_q] = ~filt_q[ptr_q];
        end

        if (cfg_hit) begin
            high_d[cfg_chan] = cfg_high_time;
            low_d[cfg_chan]  = cfg_low_time;
            cnt_d[cfg_chan]  = '0;
        end
    end

    // Channel state, input register, scan pointer and ready flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_q   <= '0;
            filt_q <= '0;
            init_q <= '0;
            ptr_q  <= '0;
            live_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                high_q[i] <= '1;
                low_q[i]  <= '1;
            end
        end else begin
            in_q   <= filter_i;
            filt_q <= filt_d;
            init_q <= init_d;
            ptr_q  <= ptr_d;
            live_q <= 1'b1;
            cnt_q  <= cnt_d;
            high_q <= high_d;
            low_q  <= low_d;
        end
    end

    assign filter_o  = filt_q;
    assign scan_ptr  = ptr_q;
    assign cfg_ready = live_q;

`ifdef UTIL_FILTER_SCHED_EVT_EN
    logic            evt_valid_q;
    logic [CH_W-1:0] evt_chan_q;
    logic            evt_level_q;

    // One-cycle event pulse in the cycle after a toggle; only one channel is visited per clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_valid_q <= 1'b0;
            evt_chan_q  <= '0;
            evt_level_q <= 1'b0;
        end else begin
            evt_valid_q <= visit_tgl;
            if (visit_tgl) begin
                evt_chan_q  <= ptr_q;
                evt_level_q <= filt_d[ptr_q];
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_chan  = evt_chan_q;
    assign evt_level = evt_level_q;
`else
    assign evt_valid = 1'b0;
    assign evt_chan  = '0;
    assign evt_level = 1'b0;
`endif

endmodule

// File: tb/tb_util_filter_sched.sv
// Self-checking bench for util_filter_sched with NUM_CH=4, CNT_W=8.
// Event checks expect real events when UTIL_FILTER_SCHED_EVT_EN is defined, zeros otherwise.
module tb_util_filter_sched;

    localparam int unsigned NCh  = 4;
    localparam int unsigned CntW = 8;

`ifdef UTIL_FILTER_SCHED_EVT_EN
    localparam bit EvtEn = 1'b1;
`else
    localparam bit EvtEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            enable = 1'b0;
    logic [NCh-1:0]  filter_i = '0;
    logic [NCh-1:0]  filter_o;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [1:0]      cfg_chan = '0;
    logic [CntW-1:0] cfg_high_time = '0;
    logic [CntW-1:0] cfg_low_time = '0;
    logic [1:0]      scan_ptr;
    logic            evt_valid;
    logic [1:0]      evt_chan;
    logic            evt_level;

    int checks = 0;
    int errors = 0;
    int evt_seen = 0;
    int evt_base;

    util_filter_sched #(
        .NUM_CH(NCh),
        .CNT_W (CntW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .filter_i     (filter_i),
        .filter_o     (filter_o),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_chan     (cfg_chan),
        .cfg_high_time(cfg_high_time),
        .cfg_low_time (cfg_low_time),
        .scan_ptr     (scan_ptr),
        .evt_valid    (evt_valid),
        .evt_chan     (evt_chan),
        .evt_level    (evt_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (evt_valid === 1'b1) evt_seen <= evt_seen + 1;
    end

    // Table entry: apply 'in' at a negedge with scan_ptr==3, wait 'rounds' scan periods so every
    // channel gets exactly 'rounds' visits of 'in', then expect filter_o == 'exp'. Channels 0..2
    // receive one further visit of 'in' before the next entry is applied.
    typedef struct {
        logic [3:0] in;
        int         rounds;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ptr(input logic [1:0] p);
        int n;
        n = 0;
        while (scan_ptr !== p && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (scan_ptr !== p) chk("wait_ptr_timeout", 8'(scan_ptr), 8'(p));
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] hi, input logic [7:0] lo);
        cfg_valid     = 1'b1;
        cfg_chan      = ch;
        cfg_high_time = hi;
        cfg_low_time  = lo;
        @(negedge clk);
        cfg_valid     = 1'b0;
    endtask

    task automatic chk_evt(input string name, input logic [1:0] ch, input logic lvl);
        chk({name, "_valid"}, 8'(evt_valid), 8'(EvtEn));
        chk({name, "_chan"},  8'(evt_chan),  EvtEn ? 8'(ch) : 8'h0);
        chk({name, "_level"}, 8'(evt_level), EvtEn ? 8'(lvl) : 8'h0);
    endtask

    initial begin
        // Thresholds (hi/lo): ch0 1/1, ch1 2/3, ch2 3/2, ch3 0(->1)/4. Start: filter_o=0101.
        vecs[0]  = '{4'b0101, 1, 4'b0101};
        vecs[1]  = '{4'b0111, 1, 4'b0101};  // ch1 cnt 1 of 2; rises on the extra visit
        vecs[2]  = '{4'b0111, 1, 4'b0111};
        vecs[3]  = '{4'b1111, 1, 4'b1111};  // ch3 threshold 0 acts as 1
        vecs[4]  = '{4'b1011, 1, 4'b1111};  // ch2 cnt 1 of 2; falls on the extra visit
        vecs[5]  = '{4'b1111, 2, 4'b1011};  // ch2 cnt 2 of 3; rises on the extra visit
        vecs[6]  = '{4'b0111, 3, 4'b1111};  // ch3 cnt 3 of 4
        vecs[7]  = '{4'b1111, 1, 4'b1111};  // ch3 matches, cnt cleared
        vecs[8]  = '{4'b0111, 3, 4'b1111};  // ch3 counts from 0 again
        vecs[9]  = '{4'b0111, 1, 4'b0111};  // ch3 falls on 4th visit
        vecs[10] = '{4'b0110, 1, 4'b0110};
        vecs[11] = '{4'b0001, 1, 4'b0111};  // ch0 rises; ch1/ch2 start counting down
        vecs[12] = '{4'b0001, 1, 4'b0001};  // ch1 falls on 3rd visit, ch2 already fell

        // Reset values and init from inputs.
        filter_i = 4'b0101;
        enable   = 1'b1;
        #1 rstn  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_filter_o", 8'(filter_o), 8'h0);
        chk("rst_scan_ptr", 8'(scan_ptr), 8'h0);
        chk("rst_cfg_ready", 8'(cfg_ready), 8'h0);
        chk("rst_evt_valid", 8'(evt_valid), 8'h0);
        rstn = 1'b1;
        adv(1);
        chk("rdy_after_rst", 8'(cfg_ready), 8'h1);
        chk("ptr_first_clk", 8'(scan_ptr), 8'h0);
        adv(4);
        chk("init_levels", 8'(filter_o), 8'h5);
        chk("init_no_evt", 8'(evt_seen), 8'h0);

        // Configure thresholds while frozen.
        enable = 1'b0;
        cfg_write(2'd0, 8'd1, 8'd1);
        cfg_write(2'd1, 8'd2, 8'd3);
        cfg_write(2'd2, 8'd3, 8'd2);
        cfg_write(2'd3, 8'd0, 8'd4);
        chk("frozen_ptr", 8'(scan_ptr), 8'h0);
        enable = 1'b1;

        evt_base = evt_seen;
        for (int i = 0; i < 13; i++) begin
            wait_ptr(2'd3);
            filter_i = vecs[i].in;
            adv(4 * vecs[i].rounds + 1);
            chk($sformatf("vec%0d", i), 8'(filter_o), 8'(vecs[i].exp));
        end
        chk("table_evt_count", 8'(evt_seen - evt_base), EvtEn ? 8'd9 : 8'd0);

        // ch1 high=3: rises on the 3rd visit with a single event.
        cfg_write(2'd1, 8'd3, 8'd3);
        wait_ptr(2'd3);
        evt_base = evt_seen;
        filter_i = 4'b0011;
        adv(7);
        chk("rise_2nd_visit", 8'(filter_o), 8'h1);
        adv(4);
        chk("rise_3rd_visit", 8'(filter_o), 8'h3);
        chk_evt("rise_evt", 2'd1, 1'b1);
        adv(1);
        chk("rise_evt_pulse", 8'(evt_valid), 8'h0);
        chk("rise_evt_once", 8'(evt_seen - evt_base), EvtEn ? 8'd1 : 8'd0);

        // ch2 at 1 with low=4: a 3-visit low glitch must not pass and must clear cnt.
        cfg_write(2'd2, 8'd1, 8'd4);
        wait_ptr(2'd3);
        filter_i = 4'b0111;
        adv(4);
        chk("ch2_high", 8'(filter_o), 8'h7);
        filter_i = 4'b0011;
        adv(12);
        chk("glitch1_held", 8'(filter_o), 8'h7);
        filter_i = 4'b0111;
        adv(4);
        chk("glitch1_end", 8'(filter_o), 8'h7);
        filter_i = 4'b0011;
        adv(12);
        chk("glitch2_cnt_cleared", 8'(filter_o), 8'h7);
        filter_i = 4'b0111;
        adv(4);
        chk("glitch2_end", 8'(filter_o), 8'h7);

        // ch0 high=5: config write colliding with the ch0 visit at cnt=2 clears cnt, no toggle.
        cfg_write(2'd0, 8'd5, 8'd1);
        wait_ptr(2'd3);
        filter_i = 4'b0110;
        adv(2);
        chk("ch0_low", 8'(filter_o), 8'h6);
        wait_ptr(2'd3);
        filter_i = 4'b0111;
        adv(6);
        wait_ptr(2'd0);
        cfg_write(2'd0, 8'd5, 8'd1);
        chk("collide_no_toggle", 8'(filter_o), 8'h6);
        chk("collide_no_evt", 8'(evt_valid), 8'h0);
        adv(16);
        chk("collide_4_more", 8'(filter_o), 8'h6);
        adv(4);
        chk("collide_5_more", 8'(filter_o), 8'h7);
        chk_evt("collide_evt", 2'd0, 1'b1);

        // ch3 high=3: freeze 20 clk after one visit, then resume and toggle on time.
        cfg_write(2'd3, 8'd3, 8'd4);
        wait_ptr(2'd3);
        filter_i = 4'b1111;
        adv(5);
        enable = 1'b0;
        adv(20);
        chk("freeze_level", 8'(filter_o), 8'h7);
        chk("freeze_ptr", 8'(scan_ptr), 8'h0);
        chk("freeze_cfg_ready", 8'(cfg_ready), 8'h1);
        enable = 1'b1;
        adv(4);
        chk("resume_2nd", 8'(filter_o), 8'h7);
        adv(4);
        chk("resume_3rd", 8'(filter_o), 8'hf);
        chk_evt("resume_evt", 2'd3, 1'b1);

        // Reset during a ch1 count, then re-init from current inputs.
        cfg_write(2'd1, 8'd3, 8'd3);
        wait_ptr(2'd3);
        filter_i = 4'b1101;
        adv(3);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_filter_o", 8'(filter_o), 8'h0);
        chk("async_rst_ptr", 8'(scan_ptr), 8'h0);
        chk("async_rst_ready", 8'(cfg_ready), 8'h0);
        chk("async_rst_evt", 8'(evt_valid), 8'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        adv(1);
        chk("rerst_ready", 8'(cfg_ready), 8'h1);
        chk("rerst_level_0", 8'(filter_o), 8'h0);
        adv(4);
        chk("reinit_levels", 8'(filter_o), 8'hd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
